// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731 configuration scheduler.
// Holds the FSM state encoding, the 24-bit I2C frame layout and the fixed init table.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT_ISSUE = 3'd1,
    S_INIT_WAIT  = 3'd2,
    S_READY      = 3'd3,
    S_Q_ISSUE    = 3'd4,
    S_Q_WAIT     = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] addr_w;
    logic [6:0] reg_addr;
    logic [8:0] data;
  } cfg_frame_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;
  localparam int         INIT_LEN     = 7;

  // Each entry is {reg[6:0], data[8:0]}, replayed in index order.
  localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
    {7'h0F, 9'h000},
    {7'h06, 9'h000},
    {7'h04, 9'h015},
    {7'h05, 9'h000},
    {7'h07, 9'h042},
    {7'h08, 9'h019},
    {7'h09, 9'h001}
  };

  function automatic cfg_frame_t make_frame(input logic [6:0] dev, input logic [15:0] entry);
    cfg_frame_t f;
    f.addr_w   = {dev, 1'b0};
    f.reg_addr = entry[15:9];
    f.data     = entry[8:0];
    return f;
  endfunction

endpackage

// File: rtl/codec_cfg_scheduler_fifo.sv
// Synchronous FIFO holding runtime register-write requests as {reg, data}.
// Full is decoded from the registered count, so a same-cycle pop never frees a slot.
module cfg_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/codec_cfg_scheduler.sv
// Sequences every WM8731 register write over the single I2C link: init table first,
// then queued runtime requests, each sent as a 24-bit frame with NACK retry.
module codec_cfg_scheduler
  import codec_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
  parameter int         QDEPTH    = 4,
  parameter int         RETRY_MAX = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_start,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [6:0]  i_req_reg,
  input  logic [8:0]  i_req_data,
  output logic        o_tx_start,
  output logic [23:0] o_tx_frame,
  input  logic        i_tx_done,
  input  logic        i_tx_nack,
  output logic        o_init_done,
  output logic        o_busy,
  output logic        o_err,
  output state_t      o_dbg_state
);
  // Handshakes: a request transfers on any clock where i_req_valid && o_req_ready.
  // A frame is offered by a one-cycle o_tx_start; i_tx_done (with i_tx_nack) closes it.
  localparam int             RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0]  RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [2:0]     INIT_LAST = 3'(INIT_LEN - 1);
  localparam int             CW        = $clog2(QDEPTH) + 1;

  state_t        state;
  logic [2:0]    init_idx;
  logic [RW-1:0] retry_cnt;
  cfg_frame_t    frame_q;

  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [15:0]   q_head;
  logic          q_pop;
  logic          retry_now;

  assign retry_now   = i_tx_nack && (retry_cnt < RETRY_LIM);
  assign q_pop       = (state == S_Q_WAIT) && i_tx_done && !retry_now;
  assign o_req_ready = !q_full;
  assign o_busy      = !(state == S_IDLE || state == S_READY) || (q_count != '0);
  assign o_tx_frame  = frame_q;
  assign o_dbg_state = state;

  cfg_fifo #(.WIDTH(16), .DEPTH(QDEPTH)) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (i_req_valid && o_req_ready),
    .wr_data ({i_req_reg, i_req_data}),
    .pop     (q_pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      init_idx    <= '0;
      retry_cnt   <= '0;
      frame_q     <= '0;
      o_tx_start  <= 1'b0;
      o_init_done <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_init_start) begin
            init_idx <= '0;
            state    <= S_INIT_ISSUE;
          end
        end
        S_INIT_ISSUE: begin
          o_tx_start <= 1'b1;
          frame_q    <= make_frame(DEV_ADDR, INIT_TABLE[init_idx]);
          state      <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (i_tx_done) begin
            if (retry_now) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_INIT_ISSUE;
            end else begin
              // A frame out of retries is dropped; the table still advances.
              retry_cnt <= '0;
              if (i_tx_nack) o_err <= 1'b1;
              if (init_idx < INIT_LAST) begin
                init_idx <= init_idx + 3'd1;
                state    <= S_INIT_ISSUE;
              end else begin
                o_init_done <= 1'b1;
                state       <= S_READY;
              end
            end
          end
        end
        S_READY: begin
          if (i_init_start) begin
            init_idx    <= '0;
            o_init_done <= 1'b0;
            state       <= S_INIT_ISSUE;
          end else if (!q_empty) begin
            state <= S_Q_ISSUE;
          end
        end
        S_Q_ISSUE: begin
          o_tx_start <= 1'b1;
          frame_q    <= make_frame(DEV_ADDR, q_head);
          state      <= S_Q_WAIT;
        end
        S_Q_WAIT: begin
          if (i_tx_done) begin
            if (retry_now) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_Q_ISSUE;
            end else begin
              retry_cnt <= '0;
              if (i_tx_nack) o_err <= 1'b1;
              state <= S_READY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Bench for codec_cfg_scheduler: frame-engine model with programmable NACKs and stall,
// expected-frame queue checked by an independent monitor on every o_tx_start.
module tb_codec_cfg_scheduler;
  import codec_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_init_start = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [6:0]  i_req_reg = '0;
  logic [8:0]  i_req_data = '0;
  logic        o_tx_start;
  logic [23:0] o_tx_frame;
  logic        i_tx_done = 1'b0;
  logic        i_tx_nack = 1'b0;
  logic        o_init_done;
  logic        o_busy;
  logic        o_err;
  state_t      o_dbg_state;

  codec_cfg_scheduler dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_init_start (i_init_start),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_reg    (i_req_reg),
    .i_req_data   (i_req_data),
    .o_tx_start   (o_tx_start),
    .o_tx_frame   (o_tx_frame),
    .i_tx_done    (i_tx_done),
    .i_tx_nack    (i_tx_nack),
    .o_init_done  (o_init_done),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int frames_seen = 0;

  // Hand-computed init frames: {0x34, reg, data}.
  logic [23:0] init_exp [7] = '{24'h341E00, 24'h340C00, 24'h340815, 24'h340A00,
                                24'h340E42, 24'h341019, 24'h341201};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (o_tx_start) begin
      frames_seen++;
      if (exp_q.size() == 0) check("unexpected_tx_start", o_tx_frame, 32'hDEAD);
      else check("tx_frame", o_tx_frame, exp_q.pop_front());
    end
  end

  // ---------------- frame engine model ----------------
  int          eng_delay   = 50;
  bit          eng_hold    = 0;
  int          nack_budget = 0;
  logic [23:0] nack_frame  = '0;
  int          last_done_cyc = 0;

  initial begin
    logic [23:0] cur;
    bit aborted;
    forever begin
      @(negedge clk);
      if (o_tx_start && !i_rst) begin
        cur = o_tx_frame;
        aborted = 0;
        for (int k = 0; k < eng_delay - 1 && !aborted; k++) begin
          @(negedge clk);
          if (i_rst) aborted = 1;
        end
        for (int k = 0; k < 5000 && eng_hold && !aborted; k++) begin
          @(negedge clk);
          if (i_rst) aborted = 1;
        end
        if (!aborted) begin
          @(negedge clk);
          if (nack_budget > 0 && cur == nack_frame) begin
            i_tx_nack = 1'b1;
            nack_budget--;
          end
          i_tx_done = 1'b1;
          last_done_cyc = cyc;
          @(negedge clk);
          i_tx_done = 1'b0;
          i_tx_nack = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_frame", o_tx_frame, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_req_ready", o_req_ready, 1);
    i_rst = 1'b0;
  endtask

  task automatic pulse_init();
    @(negedge clk);
    i_init_start = 1'b1;
    @(negedge clk);
    i_init_start = 1'b0;
  endtask

  // Queue the expected init frames; frame index 2 appears rep2 times, only the first upto frames.
  task automatic expect_init(input int rep2, input int upto);
    for (int i = 0; i < upto; i++) begin
      if (i == 2) for (int r = 0; r < rep2; r++) exp_q.push_back(init_exp[i]);
      else exp_q.push_back(init_exp[i]);
    end
  endtask

  task automatic push_req(input logic [6:0] r, input logic [8:0] d,
                          input logic [23:0] exp_f, input logic exp_ready);
    @(negedge clk);
    check("req_ready", o_req_ready, exp_ready);
    i_req_reg   = r;
    i_req_data  = d;
    i_req_valid = 1'b1;
    if (exp_ready) exp_q.push_back(exp_f);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_init_done(input string name);
    int k;
    for (k = 0; k < 3000 && !o_init_done; k++) @(negedge clk);
    if (!o_init_done) check({name, "_init_done_timeout"}, 0, 1);
    else check({name, "_init_done_latency"}, cyc - last_done_cyc, 1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000 && o_busy; k++) @(negedge clk);
    check({name, "_idle"}, o_busy, 0);
    repeat (3) @(negedge clk);
    check({name, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    do_reset();

    // Plain init plus one request pushed mid-init.
    expect_init(1, 7);
    pulse_init();
    repeat (10) @(negedge clk);
    check("init_done_low_during_init", o_init_done, 0);
    push_req(7'h02, 9'h079, 24'h340479, 1'b1);
    wait_init_done("t1");
    check("t1_err", o_err, 0);
    wait_idle("t1");

    // Two NACKs on frame 2, then ACK: no error.
    nack_frame = 24'h340815;
    nack_budget = 2;
    expect_init(3, 7);
    pulse_init();
    wait_init_done("t2");
    check("t2_err", o_err, 0);
    check("t2_nacks_used", nack_budget, 0);
    wait_idle("t2");

    // Four NACKs: frame dropped after 4 issues, error set, table continues.
    nack_budget = 4;
    expect_init(4, 7);
    pulse_init();
    wait_init_done("t3");
    check("t3_err", o_err, 1);
    check("t3_nacks_used", nack_budget, 0);
    wait_idle("t3");

    // Fill the queue against a stalled engine; fifth push refused.
    eng_hold = 1;
    push_req(7'h02, 9'h079, 24'h340479, 1'b1);
    push_req(7'h03, 9'h07F, 24'h34067F, 1'b1);
    push_req(7'h04, 9'h011, 24'h340811, 1'b1);
    push_req(7'h05, 9'h008, 24'h340A08, 1'b1);
    push_req(7'h0A, 9'h1FF, 24'h3415FF, 1'b0);
    check("t4_busy_stalled", o_busy, 1);
    eng_hold = 0;
    wait_idle("t4");

    // Reset while init frame 3 is in flight; queued request must be lost.
    do_reset();
    base = frames_seen;
    expect_init(1, 3);
    pulse_init();
    push_req(7'h03, 9'h07F, 24'h0, 1'b1);
    void'(exp_q.pop_back());
    for (int k = 0; k < 2000 && frames_seen < base + 3; k++) @(negedge clk);
    check("t5_frames_before_reset", frames_seen - base, 3);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (80) @(negedge clk);
    check("t5_no_frames_after_reset", frames_seen - base, 3);
    check("t5_queue_empty_busy", o_busy, 0);
    check("t5_state_idle", o_dbg_state, S_IDLE);
    expect_init(1, 7);
    pulse_init();
    wait_init_done("t5");
    wait_idle("t5");

    // Stray init_start mid-init and stray done in S_READY are ignored.
    base = frames_seen;
    expect_init(1, 7);
    pulse_init();
    for (int k = 0; k < 2000 && frames_seen < base + 2; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    i_init_start = 1'b1;
    @(negedge clk);
    i_init_start = 1'b0;
    wait_init_done("t6");
    wait_idle("t6");
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_frame_count", frames_seen - base, 7);
    check("t6_state_ready", o_dbg_state, S_READY);
    check("t6_busy", o_busy, 0);
    check("t6_init_done_kept", o_init_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(600000);
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_cfg_scheduler.md
# codec_cfg_scheduler

Sequences all audio-codec (WM8731) register writes over the single I2C link. At start-up it replays a fixed 7-entry init table. After that it serves runtime register-write requests (volume, path, effect changes) from a small queue. Each write goes to the downstream I2C frame engine as a 24-bit frame through a start/done handshake, with retry on NACK.

## Interface
- DEV_ADDR, 7'h1A: codec I2C address; frame byte 0 = {DEV_ADDR, 1'b0}.
- QDEPTH, 4: runtime request queue depth (power of 2, ≥2).
- RETRY_MAX, 3: re-issues per frame after NACK before giving up.
- i_clk  in  1  system clock (100 kHz I2C bit clock domain).
- i_rst  in  1  synchronous, active-high reset.
- i_init_start  in  1  pulse; run the init table.
- i_req_valid  in  1  runtime write request valid.
- o_req_ready  out  1  queue not full.
- i_req_reg  in  7  codec register address.
- i_req_data  in  9  codec register data.
- o_tx_start  out  1  one-cycle pulse; o_tx_frame is valid.
- o_tx_frame  out  24  {DEV_ADDR,1'b0,reg[6:0],data[8:0]}.
- i_tx_done  in  1  pulse from frame engine; frame finished.
- i_tx_nack  in  1  qualified by i_tx_done; a NACK was seen.
- o_init_done  out  1  level; init table completed.
- o_busy  out  1  a frame is in flight or pending.
- o_err  out  1  sticky; a frame was dropped after retries.

## Operation
- Init table, in order (reg, data): (0x0F,0x000) reset; (0x06,0x000) power up; (0x04,0x015); (0x05,0x000); (0x07,0x042); (0x08,0x019); (0x09,0x001) activate.
- FSM states:
  - S_IDLE → S_INIT_ISSUE on i_init_start.
  - S_INIT_ISSUE → S_INIT_WAIT, pulsing o_tx_start.
  - S_INIT_WAIT on done: if index<6, index++ and → S_INIT_ISSUE; else set o_init_done and → S_READY.
  - S_READY → S_Q_ISSUE if the queue is non-empty; → S_INIT_ISSUE (index=0, o_init_done cleared) on i_init_start.
  - S_Q_ISSUE → S_Q_WAIT.
  - S_Q_WAIT on done → S_READY, popping the queue entry.
- Init has absolute priority. Queue entries are never dispatched while o_init_done=0.
- NACK handling: on done with nack, if retry_cnt<RETRY_MAX, increment and re-issue the same frame. Otherwise set o_err, reset retry_cnt and advance as on success (skip the entry). retry_cnt clears on every advance.
- Queue pushes are accepted in any state, including during init. Push occurs when i_req_valid && o_req_ready.
- i_init_start is ignored in every state except S_IDLE and S_READY.
- i_tx_done is ignored outside the WAIT states.
- o_busy = state ∉ {S_IDLE, S_READY} || queue non-empty.

## Timing
- Reset: state S_IDLE, queue empty, index 0, retry_cnt 0. All outputs 0 except o_req_ready=1.
- Reset mid-frame aborts immediately. No o_tx_start is emitted until a new i_init_start.
- o_tx_start rises the cycle after entry to an ISSUE state, i.e. 1 cycle after i_init_start or after the done that triggers the re-issue.
- o_tx_frame is registered. It is stable from o_tx_start until the matching i_tx_done.
- A queued entry dispatches 1 cycle after S_READY is entered.
- o_req_ready is derived from the registered count. A pop in the same cycle does not free a slot for a push when full; a push when full is refused.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- Counters: the queue pointers are log2(QDEPTH) bits and wrap naturally. The count is log2(QDEPTH)+1 bits.

## Structure
- Package codec_cfg_pkg holds:
  - state enum
  - cfg_frame_t packed struct {addr_w[7:0], reg[6:0], data[8:0]}
  - INIT_LEN=7 and the init table as a localparam array
  - the default DEV_ADDR
- Sub-module cfg_fifo: synchronous FIFO, width 16, depth QDEPTH, with full/empty/count outputs.

## Test plan
- Reset, then i_init_start; the model ACKs every frame after 50 cycles → 7 frames are issued, first 24'h341E00 and last 24'h341201. o_init_done rises the cycle after the 7th done; no o_err.
- Push (0x02,0x079) during init → it is issued only after o_init_done, as 24'h340479.
- Model NACKs frame 2 twice, then ACKs → 24'h340815 is issued 3 times and o_err stays 0. With 4 NACKs, the frame is issued 4 times, o_err=1 and frame 3 follows.
- Fill the queue with 5 pushes while the engine is stalled → the first 4 are accepted and the 5th sees o_req_ready=0. Frames drain in FIFO order.
- Assert i_rst between o_tx_start and done of init frame 3 → all outputs return to reset values and the queue is empty. A later i_init_start restarts from 24'h341E00.
- i_init_start pulsed mid-init and stray i_tx_done in S_READY → both are ignored, with no extra frame and no index skip.
